// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, bubble opcode and the hazard controller state encoding.
package mips_pkg;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpNop   = 6'b111000;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StStall   = 2'd1,
      StFlush   = 2'd2,
      StMemWait = 2'd3
   } hcu_state_e;

   function automatic logic is_branch(logic [5:0] op);
      return (op == OpBeq) || (op == OpBne);
   endfunction

   function automatic logic is_jump(logic [5:0] op);
      return (op == OpJ) || (op == OpJal);
   endfunction

   // Opcodes whose rt field is a source operand rather than a destination.
   function automatic logic uses_rt(logic [5:0] op);
      return (op == OpRtype) || (op == OpBeq) || (op == OpBne) || (op == OpSw);
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline, slave is the controller.
interface hazard_control_unit_if #(
   parameter int unsigned CNT_W = 16
);
   logic [5:0]       id_opcode;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             ex_mem_read;
   logic             ex_reg_write;
   logic [4:0]       ex_dest;
   logic             branch_taken;
   logic             mem_busy;
   logic             pc_hold;
   logic             if_id_enable;
   logic             if_id_reset;
   logic             id_ex_bubble;
   logic             pipe_freeze;
   logic [1:0]       state_dbg;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output id_opcode, id_rs, id_rt, ex_mem_read, ex_reg_write, ex_dest, branch_taken, mem_busy,
      input  pc_hold, if_id_enable, if_id_reset, id_ex_bubble, pipe_freeze, state_dbg,
      input  stall_count, flush_count
   );

   modport slave (
      input  id_opcode, id_rs, id_rt, ex_mem_read, ex_reg_write, ex_dest, branch_taken, mem_busy,
      output pc_hold, if_id_enable, if_id_reset, id_ex_bubble, pipe_freeze, state_dbg,
      output stall_count, flush_count
   );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use / branch-dependence detection and stall length for the ID instruction.
module hazard_detect
   import mips_pkg::*;
#(
   parameter logic [5:0] NOP_OPCODE = OpNop
) (
   input  logic [5:0] id_opcode_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       ex_mem_read_i,
   input  logic       ex_reg_write_i,
   input  logic [4:0] ex_dest_i,
   output logic       stall_o,
   output logic [1:0] stall_len_o
);

   logic id_nop;
   logic rs_hit;
   logic rt_hit;
   logic load_use;
   logic br_dep;

   // Register 0 never hazards; a bubble in ID never hazards regardless of its register fields.
   always_comb begin
      id_nop      = (id_opcode_i == NOP_OPCODE);
      rs_hit      = (ex_dest_i != 5'd0) && (ex_dest_i == id_rs_i);
      rt_hit      = (ex_dest_i != 5'd0) && (ex_dest_i == id_rt_i);
      load_use    = !id_nop && ex_mem_read_i && (rs_hit || (uses_rt(id_opcode_i) && rt_hit));
      br_dep      = !id_nop && is_branch(id_opcode_i) && ex_reg_write_i && (rs_hit || rt_hit);
      stall_o     = load_use || br_dep;
      // A branch waiting on a load needs the value out of MEM, one cycle later than an ALU result.
      stall_len_o = (br_dep && ex_mem_read_i) ? 2'd2 : 2'd1;
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: stalls, flushes, memory-wait freezes and event counters.
module hazard_control_unit
   import mips_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter logic [5:0]  NOP_OPCODE = OpNop
) (
   input  logic                  clk,
   input  logic                  reset,
   hazard_control_unit_if.slave  bus
);

   hcu_state_e       state_q, state_d;
   hcu_state_e       ret_q, ret_d;
   hcu_state_e       eff_state;
   logic [1:0]       remain_q, remain_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic       stall;
   logic [1:0] stall_len;
   logic       flush_req;

   logic pc_hold;
   logic if_id_enable;
   logic if_id_reset;
   logic id_ex_bubble;
   logic pipe_freeze;

   hazard_detect #(
      .NOP_OPCODE (NOP_OPCODE)
   ) u_hazard_detect (
      .id_opcode_i    (bus.id_opcode),
      .id_rs_i        (bus.id_rs),
      .id_rt_i        (bus.id_rt),
      .ex_mem_read_i  (bus.ex_mem_read),
      .ex_reg_write_i (bus.ex_reg_write),
      .ex_dest_i      (bus.ex_dest),
      .stall_o        (stall),
      .stall_len_o    (stall_len)
   );

   // Next-state and control outputs; priority is freeze, then stall, then flush.
   always_comb begin
      pc_hold      = 1'b0;
      if_id_enable = 1'b0;
      if_id_reset  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      state_d      = state_q;
      ret_d        = ret_q;
      remain_d     = remain_q;
      flush_req    = is_jump(bus.id_opcode) || (is_branch(bus.id_opcode) && bus.branch_taken);
      // Once memory is ready, behave as the interrupted state in the same cycle so no slot is lost.
      eff_state    = (state_q == StMemWait) ? ret_q : state_q;

      if (bus.mem_busy) begin
         pc_hold      = 1'b1;
         if_id_enable = 1'b1;
         pipe_freeze  = 1'b1;
         state_d      = StMemWait;
         if (state_q != StMemWait) begin
            ret_d = state_q;
         end
      end else begin
         case (eff_state)
            StStall: begin
               pc_hold      = 1'b1;
               if_id_enable = 1'b1;
               id_ex_bubble = 1'b1;
               if (remain_q <= 2'd1) begin
                  state_d  = StRun;
                  remain_d = 2'd0;
               end else begin
                  state_d  = StStall;
                  remain_d = remain_q - 2'd1;
               end
            end
            StRun, StFlush: begin
               // FLUSH holds a bubble in ID, so evaluating it as RUN lands back in RUN.
               if (stall) begin
                  pc_hold      = 1'b1;
                  if_id_enable = 1'b1;
                  id_ex_bubble = 1'b1;
                  if (stall_len > 2'd1) begin
                     state_d  = StStall;
                     remain_d = stall_len - 2'd1;
                  end else begin
                     state_d  = StRun;
                  end
               end else if (flush_req) begin
                  if_id_reset = 1'b1;
                  state_d     = StFlush;
               end else begin
                  state_d = StRun;
               end
            end
            default: state_d = StRun;
         endcase
      end

      if (reset) begin
         pc_hold      = 1'b0;
         if_id_enable = 1'b0;
         if_id_reset  = 1'b1;
         id_ex_bubble = 1'b1;
         pipe_freeze  = 1'b0;
      end
   end

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (if_id_reset && !reset && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // State, saved return state, remain and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StRun;
         ret_q       <= StRun;
         remain_q    <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         remain_q    <= remain_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.pc_hold      = pc_hold;
   assign bus.if_id_enable = if_id_enable;
   assign bus.if_id_reset  = if_id_reset;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.pipe_freeze  = pipe_freeze;
   assign bus.state_dbg    = state_q;
   assign bus.stall_count  = stall_cnt_q;
   assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit with hand-computed expectations.
module tb_hazard_control_unit;
   import mips_pkg::*;

   // Control vector order: {pc_hold, if_id_enable, if_id_reset, id_ex_bubble, pipe_freeze}
   localparam logic [4:0] CtlIdle   = 5'b00000;
   localparam logic [4:0] CtlStall  = 5'b11010;
   localparam logic [4:0] CtlFlush  = 5'b00100;
   localparam logic [4:0] CtlFreeze = 5'b11001;
   localparam logic [4:0] CtlReset  = 5'b00110;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   hazard_control_unit_if #(.CNT_W(16)) bus ();

   hazard_control_unit #(
      .CNT_W      (16),
      .NOP_OPCODE (6'b111000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] ctl();
      return {bus.pc_hold, bus.if_id_enable, bus.if_id_reset, bus.id_ex_bubble, bus.pipe_freeze};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic rw, input logic [4:0] dest,
                         input logic bt, input logic mb);
      bus.id_opcode    = op;
      bus.id_rs        = rs;
      bus.id_rt        = rt;
      bus.ex_mem_read  = mr;
      bus.ex_reg_write = rw;
      bus.ex_dest      = dest;
      bus.branch_taken = bt;
      bus.mem_busy     = mb;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      set_in(OpNop, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("rst_ctl", ctl(), CtlReset);
      check_eq("rst_state", bus.state_dbg, 0);
      check_eq("rst_stall_cnt", bus.stall_count, 0);
      check_eq("rst_flush_cnt", bus.flush_count, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_eq("idle_ctl", ctl(), CtlIdle);

      // Load-use: lw $2 in EX, add rs=2 in ID -> one stall cycle
      set_in(OpRtype, 5'd2, 5'd5, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
      check_eq("lu_ctl", ctl(), CtlStall);
      tick();
      check_eq("lu_state", bus.state_dbg, 0);
      check_eq("lu_stall_cnt", bus.stall_count, 1);
      set_in(OpRtype, 5'd2, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("lu_release", ctl(), CtlIdle);
      tick();

      // Branch on a load result: two stall cycles, then flush when taken
      set_in(OpBeq, 5'd3, 5'd7, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      check_eq("br2_c1_ctl", ctl(), CtlStall);
      tick();
      check_eq("br2_c1_state", bus.state_dbg, 1);
      set_in(OpBeq, 5'd3, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      check_eq("br2_c2_ctl", ctl(), CtlStall);
      tick();
      check_eq("br2_c2_state", bus.state_dbg, 0);
      check_eq("br2_flush_ctl", ctl(), CtlFlush);
      tick();
      check_eq("br2_flush_state", bus.state_dbg, 2);
      check_eq("br2_stall_cnt", bus.stall_count, 3);
      check_eq("br2_flush_cnt", bus.flush_count, 1);
      set_in(OpNop, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("br2_after_ctl", ctl(), CtlIdle);
      tick();
      check_eq("br2_after_state", bus.state_dbg, 0);

      // Jump: one flush cycle, FLUSH state for one cycle
      set_in(OpJ, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("j_ctl", ctl(), CtlFlush);
      tick();
      check_eq("j_state_flush", bus.state_dbg, 2);
      set_in(OpNop, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("j_nop_ctl", ctl(), CtlIdle);
      tick();
      check_eq("j_state_run", bus.state_dbg, 0);
      check_eq("j_flush_cnt", bus.flush_count, 2);

      // mem_busy for 3 cycles in the middle of a 2-cycle branch stall
      set_in(OpBeq, 5'd4, 5'd8, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      check_eq("mw_c1_ctl", ctl(), CtlStall);
      tick();
      check_eq("mw_c1_state", bus.state_dbg, 1);
      for (int i = 0; i < 3; i++) begin
         set_in(OpBeq, 5'd4, 5'd8, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
         check_eq("mw_freeze_ctl", ctl(), CtlFreeze);
         tick();
         check_eq("mw_freeze_state", bus.state_dbg, 3);
      end
      check_eq("mw_stall_cnt", bus.stall_count, 7);
      set_in(OpBeq, 5'd4, 5'd8, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      check_eq("mw_resume_ctl", ctl(), CtlStall);
      tick();
      check_eq("mw_resume_state", bus.state_dbg, 0);
      check_eq("mw_flush_ctl", ctl(), CtlFlush);
      tick();
      check_eq("mw_stall_cnt2", bus.stall_count, 8);
      check_eq("mw_flush_cnt", bus.flush_count, 3);
      set_in(OpNop, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();

      // Freeze beats a taken branch; branch re-evaluated after memory is ready
      set_in(OpBne, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      check_eq("fz_br_ctl", ctl(), CtlFreeze);
      tick();
      check_eq("fz_br_state", bus.state_dbg, 3);
      set_in(OpBne, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      check_eq("fz_br_flush_ctl", ctl(), CtlFlush);
      tick();
      check_eq("fz_br_flush_state", bus.state_dbg, 2);
      set_in(OpNop, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();

      // ALU dependence plus taken branch: 1-cycle stall wins, flush follows
      set_in(OpBeq, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
      check_eq("st_br_ctl", ctl(), CtlStall);
      tick();
      check_eq("st_br_state", bus.state_dbg, 0);
      set_in(OpBeq, 5'd6, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      check_eq("st_br_flush_ctl", ctl(), CtlFlush);
      tick();
      check_eq("st_br_stall_cnt", bus.stall_count, 10);
      check_eq("st_br_flush_cnt", bus.flush_count, 5);
      set_in(OpNop, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();

      // Register-0 and rt-usage boundaries (combinational only)
      set_in(OpRtype, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      check_eq("r0_no_stall", ctl(), CtlIdle);
      set_in(OpSw, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      check_eq("sw_rt_stall", ctl(), CtlStall);
      set_in(OpLw, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      check_eq("lw_rt_no_stall", ctl(), CtlIdle);
      set_in(OpNop, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      check_eq("nop_no_stall", ctl(), CtlIdle);
      set_in(OpNop, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();

      // Asynchronous reset in the middle of a STALL
      set_in(OpBeq, 5'd3, 5'd7, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      tick();
      check_eq("ar_state_stall", bus.state_dbg, 1);
      reset = 1'b1;
      #1;
      check_eq("ar_ctl", ctl(), CtlReset);
      check_eq("ar_state", bus.state_dbg, 0);
      check_eq("ar_stall_cnt", bus.stall_count, 0);
      check_eq("ar_flush_cnt", bus.flush_count, 0);
      tick();
      reset = 1'b0;
      set_in(OpNop, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check_eq("ar_release_ctl", ctl(), CtlIdle);
      tick();
      check_eq("ar_release_state", bus.state_dbg, 0);

      // Stall counter saturation: hold a load-use stall until the counter reaches all-ones
      set_in(OpRtype, 5'd2, 5'd5, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
      for (int i = 0; i < 65534; i++) begin
         tick();
      end
      check_eq("sat_fffe", bus.stall_count, 32'hFFFE);
      tick();
      tick();
      check_eq("sat_ffff", bus.stall_count, 32'hFFFF);
      check_eq("sat_flush_cnt", bus.flush_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it decides whether the IF/ID register loads, holds or flushes, whether the PC advances, and whether a bubble enters ID/EX. It handles load-use stalls, multi-cycle stalls for branches resolved in ID, control-transfer flushes and data-memory wait freezes. It also keeps saturating stall and flush event counters.

## Interface
Parameters:
- CNT_W, 16, width of the event counters
- NOP_OPCODE, 6'b111000, opcode the control unit decodes as a bubble

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- id_opcode  in  6  opcode of the instruction in ID
- id_rs, id_rt  in  5 each  source registers of the ID instruction
- ex_mem_read  in  1  EX-stage instruction is a load
- ex_reg_write  in  1  EX-stage instruction writes a register
- ex_dest  in  5  EX-stage destination register (rt for loads, rd for R-type)
- branch_taken  in  1  ID branch comparator result; valid only when id_opcode is beq/bne
- mem_busy  in  1  data memory not ready; whole pipeline must freeze
- pc_hold  out  1  1 = PC keeps its value
- if_id_enable  out  1  1 = IF/ID holds; 0 = IF/ID loads
- if_id_reset  out  1  1 = IF/ID loads the NOP instruction (flush)
- id_ex_bubble  out  1  1 = ID/EX loads a NOP instead of the decoded instruction
- pipe_freeze  out  1  1 = ID/EX, EX/MEM and MEM/WB hold
- state_dbg  out  2  current FSM state
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Opcodes: R-type 000000, beq 000100, bne 000101, j 000010, jal 000011, lw 100011, sw 101011.
- uses_rt = R-type, beq, bne or sw. Register 0 never causes a hazard.
- load_use = ex_mem_read & ex_dest≠0 & (ex_dest==id_rs | (uses_rt & ex_dest==id_rt)).
- br_dep = id is beq/bne & ex_reg_write & ex_dest≠0 & (ex_dest==id_rs | ex_dest==id_rt).
- Branch stall length: 2 cycles if br_dep & ex_mem_read, otherwise 1 cycle.
- FSM states: RUN=0, STALL=1, FLUSH=2, MEM_WAIT=3. A 2-bit remain counter goes with STALL.
- Priority in every state: mem_busy > pending/new stall > flush > normal.
- mem_busy=1 (any state):
  - pc_hold=1, if_id_enable=1, pipe_freeze=1, id_ex_bubble=0, if_id_reset=0.
  - Next state is MEM_WAIT. The return state and remain value are saved unchanged.
  - When mem_busy falls, go back to the saved state.
- RUN with load_use or br_dep:
  - pc_hold=1, if_id_enable=1, id_ex_bubble=1 this cycle.
  - If the total stall length is >1, go to STALL with remain = length−1. Otherwise stay in RUN.
- STALL:
  - Same outputs as a RUN stall.
  - remain decrements each non-frozen cycle. At remain==1, next state is RUN.
- RUN, no stall, and (j | jal | (beq/bne & branch_taken)):
  - if_id_reset=1, pc_hold=0, if_id_enable=0.
  - Next state is FLUSH.
- FLUSH: lasts one cycle. Outputs are evaluated as in RUN (a NOP in ID never hazards). Next state is RUN.
- Idle outputs: pc_hold=0, if_id_enable=0, if_id_reset=0, id_ex_bubble=0, pipe_freeze=0.
- stall_count increments on every cycle with pc_hold=1, including MEM_WAIT.
- flush_count increments on every cycle with if_id_reset=1 outside reset.
- Both counters saturate at all-ones.

## Timing
- Control outputs are combinational from the registered state and the current inputs. They take effect at the next clk edge (zero-cycle latency).
- State, remain and counters update on the rising edge of clk.
- While reset=1, asynchronously:
  - state=RUN, remain=0, counters=0.
  - if_id_reset=1, id_ex_bubble=1, pc_hold=0, if_id_enable=0, pipe_freeze=0.
- Reset asserted mid-STALL or mid-MEM_WAIT abandons it. After release, start from RUN.
- mem_busy in the same cycle as a taken branch: freeze wins and no flush happens. The branch is re-evaluated when mem_busy falls.
- A stall and a taken branch in the same cycle: the stall wins. The flush occurs on the first unstalled cycle.
- Counter at all-ones plus an increment event: the counter stays at all-ones.

## Structure
- mips_pkg holds the opcode constants (including NOP_OPCODE) and the FSM state enum. The decode stage and the control unit share them.
- One sub-module, hazard_detect: purely combinational load_use, br_dep and stall-length evaluation.
- The FSM, saturating counters and output mux stay in hazard_control_unit.

## Test plan
- lw $2 in EX (ex_mem_read=1, ex_dest=2), add using rs=2 in ID → exactly 1 cycle of pc_hold=1, if_id_enable=1, id_ex_bubble=1; stall_count=1.
- lw $3 in EX, beq rs=3 in ID → 2 stall cycles (state RUN→STALL→RUN), then a flush cycle if branch_taken=1; stall_count=2, flush_count=1.
- j in ID, no hazards → if_id_reset=1 for one cycle, state_dbg=2 for the following cycle, then 0.
- mem_busy held 3 cycles during the STALL of the previous case → pipe_freeze=1 for 3 cycles; remain is preserved, and exactly 1 more stall cycle follows.
- lw with ex_dest=0 against rs=0 → no stall; also force stall_count=16'hFFFE and stall twice → count stays at 16'hFFFF.
- Assert reset asynchronously mid-STALL → immediate if_id_reset=1, id_ex_bubble=1, counters 0; state_dbg=0 after release.
